// File: rtl/vending_pkg.sv
// Shared vending definitions: coin constants, dispenser FSM states, coin legality.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   COIN_W / COIN_1 / COIN_5 / COIN_10  coin encoding used on every coin bus
//   disp_state_t                         change_dispenser state encoding
//   coin_is_legal()                      true for 1, 5 and 10 only; also used by
//                                        the acceptance side so both agree on legality
package vending_pkg;

  localparam int COIN_W = 4;

  localparam logic [COIN_W-1:0] COIN_NONE = 4'd0;
  localparam logic [COIN_W-1:0] COIN_1    = 4'd1;
  localparam logic [COIN_W-1:0] COIN_5    = 4'd5;
  localparam logic [COIN_W-1:0] COIN_10   = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_PRESENT = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } disp_state_t;

  function automatic logic coin_is_legal(input logic [COIN_W-1:0] coin);
    return (coin == COIN_1) || (coin == COIN_5) || (coin == COIN_10);
  endfunction

endpackage : vending_pkg

// File: rtl/change_dispenser_coin_stock.sv
// Per-denomination coin stock: three saturating up/down counters.
// Latency: refill and dispense decrement take effect on the next clock edge.
// Backpressure: none; a refill is accepted every cycle, illegal denominations dropped.
//
// Ports:
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   refill_valid, refill_coin    one coin added per cycle when refill_coin is legal
//   dec, dec_coin                remove one coin of dec_coin (never issued at zero)
//   stock_1, stock_5, stock_10   current counts, reset to INIT_STOCK
module coin_stock
  import vending_pkg::*;
#(
  parameter int CNT_W      = 6,
  parameter int INIT_STOCK = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              refill_valid,
  input  logic [COIN_W-1:0] refill_coin,
  input  logic              dec,
  input  logic [COIN_W-1:0] dec_coin,
  output logic [CNT_W-1:0]  stock_1,
  output logic [CNT_W-1:0]  stock_5,
  output logic [CNT_W-1:0]  stock_10
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_STOCK);

  // A simultaneous refill and dispense of one denomination cancel out, so a
  // full counter is not clipped by the refill before the dispense lands.
  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cnt,
                                                 input logic            inc,
                                                 input logic            dcr);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (inc && !dcr) begin
      res = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    end else if (dcr && !inc) begin
      res = (cnt == '0) ? cnt : cnt - 1'b1;
    end
    return res;
  endfunction

  logic refill_ok;
  logic inc_1, inc_5, inc_10;
  logic dec_1, dec_5, dec_10;

  always_comb begin
    refill_ok = refill_valid && coin_is_legal(refill_coin);
    inc_1     = refill_ok && (refill_coin == COIN_1);
    inc_5     = refill_ok && (refill_coin == COIN_5);
    inc_10    = refill_ok && (refill_coin == COIN_10);
    dec_1     = dec && (dec_coin == COIN_1);
    dec_5     = dec && (dec_coin == COIN_5);
    dec_10    = dec && (dec_coin == COIN_10);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stock_1  <= CNT_INIT;
      stock_5  <= CNT_INIT;
      stock_10 <= CNT_INIT;
    end else begin
      stock_1  <= next_cnt(stock_1,  inc_1,  dec_1);
      stock_5  <= next_cnt(stock_5,  inc_5,  dec_5);
      stock_10 <= next_cnt(stock_10, inc_10, dec_10);
    end
  end

endmodule : coin_stock

// File: rtl/change_dispenser.sv
// Change dispenser: pays an amount out as greedy 10/5/1 coins to the hopper.
// Latency: 2 cycles minimum per coin (SELECT + PRESENT); done 2 cycles after start for amount 0.
// Backpressure: coin held on coin_valid/coin_value until coin_ready, indefinitely.
//
// Ports:
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   start, amount                dispense request, accepted only in IDLE
//   refill_valid, refill_coin    service refill, one coin per cycle, any state
//   coin_ready                   hopper accepts the presented coin this cycle
//   coin_valid, coin_value       coin presented to the hopper (value 0 when idle)
//   busy, done, short_err        status; done/short_err are one-cycle pulses
//   remaining                    unpaid change; kept after short_err until next start
//   stock_1, stock_5, stock_10   current coin counts
module change_dispenser
  import vending_pkg::*;
#(
  parameter int AMT_W      = 8,
  parameter int CNT_W      = 6,
  parameter int INIT_STOCK = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AMT_W-1:0]  amount,
  input  logic              refill_valid,
  input  logic [COIN_W-1:0] refill_coin,
  input  logic              coin_ready,
  output logic              coin_valid,
  output logic [COIN_W-1:0] coin_value,
  output logic              busy,
  output logic              done,
  output logic              short_err,
  output logic [AMT_W-1:0]  remaining,
  output logic [CNT_W-1:0]  stock_1,
  output logic [CNT_W-1:0]  stock_5,
  output logic [CNT_W-1:0]  stock_10
);

  disp_state_t       state_q, state_d;
  logic [AMT_W-1:0]  remaining_q;
  logic [COIN_W-1:0] coin_q;
  logic [COIN_W-1:0] pick;
  logic              xfer;

  // Greedy pick from registered stock: a refill landing during SELECT only
  // influences the next SELECT. A coin is only picked when it fits in
  // remaining, so the subtraction on transfer cannot underflow.
  always_comb begin
    pick = COIN_NONE;
    if (remaining_q >= AMT_W'(COIN_10) && stock_10 != '0) begin
      pick = COIN_10;
    end else if (remaining_q >= AMT_W'(COIN_5) && stock_5 != '0) begin
      pick = COIN_5;
    end else if (stock_1 != '0) begin
      pick = COIN_1;
    end
  end

  assign xfer = (state_q == ST_PRESENT) && coin_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    coin_valid = 1'b0;
    coin_value = COIN_NONE;
    busy       = 1'b1;
    done       = 1'b0;
    short_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (remaining_q == '0) begin
          state_d = ST_DONE;
        end else if (pick != COIN_NONE) begin
          state_d = ST_PRESENT;
        end else begin
          state_d = ST_ERROR;
        end
      end
      ST_PRESENT: begin
        coin_valid = 1'b1;
        coin_value = coin_q;
        if (coin_ready) begin
          state_d = ST_SELECT;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERROR: begin
        short_err = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath: remaining and the coin held stable across the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q <= '0;
      coin_q      <= COIN_NONE;
    end else begin
      if (state_q == ST_IDLE && start) begin
        remaining_q <= amount;
      end else if (xfer) begin
        remaining_q <= remaining_q - AMT_W'(coin_q);
      end
      if (state_q == ST_SELECT && remaining_q != '0 && pick != COIN_NONE) begin
        coin_q <= pick;
      end
    end
  end

  assign remaining = remaining_q;

  coin_stock #(
    .CNT_W      (CNT_W),
    .INIT_STOCK (INIT_STOCK)
  ) u_coin_stock (
    .clk          (clk),
    .rst          (rst),
    .refill_valid (refill_valid),
    .refill_coin  (refill_coin),
    .dec          (xfer),
    .dec_coin     (coin_q),
    .stock_1      (stock_1),
    .stock_5      (stock_5),
    .stock_10     (stock_10)
  );

endmodule : change_dispenser

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy coin order, stock limits, hopper stall, refill, reset.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: coin_ready driven directly by the stimulus sequence.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] amount;
  logic       refill_valid;
  logic [3:0] refill_coin;
  logic       coin_ready;
  logic       coin_valid;
  logic [3:0] coin_value;
  logic       busy;
  logic       done;
  logic       short_err;
  logic [7:0] remaining;
  logic [5:0] stock_1;
  logic [5:0] stock_5;
  logic [5:0] stock_10;

  int checks = 0;
  int passed = 0;

  logic [3:0] coins[$];
  logic [3:0] exp_q[$];
  logic       got_done;
  logic       got_err;

  always #5 clk = ~clk;

  change_dispenser dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .amount       (amount),
    .refill_valid (refill_valid),
    .refill_coin  (refill_coin),
    .coin_ready   (coin_ready),
    .coin_valid   (coin_valid),
    .coin_value   (coin_value),
    .busy         (busy),
    .done         (done),
    .short_err    (short_err),
    .remaining    (remaining),
    .stock_1      (stock_1),
    .stock_5      (stock_5),
    .stock_10     (stock_10)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Pulse start, then collect transferred coins until done or short_err.
  task automatic dispense(input logic [7:0] amt);
    start  = 1'b1;
    amount = amt;
    step();
    start  = 1'b0;
    coins.delete();
    got_done = 1'b0;
    got_err  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (coin_valid && coin_ready) coins.push_back(coin_value);
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (short_err) begin
        got_err = 1'b1;
        break;
      end
      step();
    end
    check("dispense_terminated", {31'd0, got_done | got_err}, 32'd1);
  endtask

  task automatic check_coins(input string tag);
    check({tag, "_count"}, coins.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < coins.size(); i++) begin
      check($sformatf("%s_coin%0d", tag, i), {28'd0, coins[i]}, {28'd0, exp_q[i]});
    end
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !coin_valid; i++) step();
    check("wait_coin_valid", {31'd0, coin_valid}, 32'd1);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    amount       = 8'd0;
    refill_valid = 1'b0;
    refill_coin  = 4'd0;
    coin_ready   = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_coin_valid", {31'd0, coin_valid}, 32'd0);
    check("rst_coin_value", {28'd0, coin_value}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_short_err", {31'd0, short_err}, 32'd0);
    check("rst_remaining", {24'd0, remaining}, 32'd0);
    check("rst_stock_1", {26'd0, stock_1}, 32'd10);
    check("rst_stock_5", {26'd0, stock_5}, 32'd10);
    check("rst_stock_10", {26'd0, stock_10}, 32'd10);

    // 17 -> 10, 5, 1, 1
    dispense(8'd17);
    exp_q = '{4'd10, 4'd5, 4'd1, 4'd1};
    check_coins("amt17");
    check("amt17_done", {31'd0, got_done}, 32'd1);
    check("amt17_remaining", {24'd0, remaining}, 32'd0);
    check("amt17_stock_10", {26'd0, stock_10}, 32'd9);
    check("amt17_stock_5", {26'd0, stock_5}, 32'd9);
    check("amt17_stock_1", {26'd0, stock_1}, 32'd8);
    step();
    check("amt17_done_one_cycle", {31'd0, done}, 32'd0);
    check("amt17_idle_busy", {31'd0, busy}, 32'd0);

    // Drain the tens, then 20 must come out as four fives
    dispense(8'd90);
    check("amt90_count", coins.size(), 32'd9);
    check("amt90_stock_10", {26'd0, stock_10}, 32'd0);
    step();
    dispense(8'd20);
    exp_q = '{4'd5, 4'd5, 4'd5, 4'd5};
    check_coins("amt20");
    check("amt20_done", {31'd0, got_done}, 32'd1);
    check("amt20_stock_5", {26'd0, stock_5}, 32'd5);
    step();

    // Leave stock_5=0, stock_1=2
    dispense(8'd25);
    check("amt25_stock_5", {26'd0, stock_5}, 32'd0);
    step();
    dispense(8'd6);
    check("amt6_stock_1", {26'd0, stock_1}, 32'd2);
    step();

    // 8 with only two ones: pays 1,1 then short_err with 6 outstanding
    dispense(8'd8);
    exp_q = '{4'd1, 4'd1};
    check_coins("amt8");
    check("amt8_short_err", {31'd0, got_err}, 32'd1);
    check("amt8_no_done", {31'd0, got_done}, 32'd0);
    check("amt8_remaining", {24'd0, remaining}, 32'd6);
    step();
    check("amt8_busy_after", {31'd0, busy}, 32'd0);
    check("amt8_err_one_cycle", {31'd0, short_err}, 32'd0);
    check("amt8_remaining_kept", {24'd0, remaining}, 32'd6);

    // Refill three tens, then stall the hopper on a 10
    refill_valid = 1'b1;
    refill_coin  = 4'd10;
    step();
    step();
    step();
    refill_valid = 1'b0;
    check("refill_stock_10", {26'd0, stock_10}, 32'd3);
    coin_ready = 1'b0;
    start      = 1'b1;
    amount     = 8'd10;
    step();
    start = 1'b0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_valid", i), {31'd0, coin_valid}, 32'd1);
      check($sformatf("stall%0d_value", i), {28'd0, coin_value}, 32'd10);
      check($sformatf("stall%0d_stock_10", i), {26'd0, stock_10}, 32'd3);
      start  = (i == 2);
      amount = 8'd50;
      step();
    end
    start = 1'b0;
    check("stall_start_ignored", {24'd0, remaining}, 32'd10);
    coin_ready = 1'b1;
    step();
    check("stall_xfer_stock_10", {26'd0, stock_10}, 32'd2);
    check("stall_xfer_remaining", {24'd0, remaining}, 32'd0);
    check("stall_xfer_valid_drop", {31'd0, coin_valid}, 32'd0);
    step();
    check("stall_done", {31'd0, done}, 32'd1);
    step();
    check("stall_idle", {31'd0, busy}, 32'd0);

    // Refill of 5 coinciding with a 5 transfer nets to zero
    refill_valid = 1'b1;
    refill_coin  = 4'd5;
    step();
    step();
    refill_valid = 1'b0;
    check("refill_stock_5", {26'd0, stock_5}, 32'd2);
    coin_ready = 1'b0;
    start      = 1'b1;
    amount     = 8'd5;
    step();
    start = 1'b0;
    wait_valid();
    check("net_coin_value", {28'd0, coin_value}, 32'd5);
    coin_ready   = 1'b1;
    refill_valid = 1'b1;
    refill_coin  = 4'd5;
    step();
    refill_valid = 1'b0;
    check("net_stock_5", {26'd0, stock_5}, 32'd2);
    check("net_remaining", {24'd0, remaining}, 32'd0);
    step();
    check("net_done", {31'd0, done}, 32'd1);
    step();

    // Illegal refill denomination changes nothing
    refill_valid = 1'b1;
    refill_coin  = 4'd7;
    step();
    refill_valid = 1'b0;
    check("illegal_stock_1", {26'd0, stock_1}, 32'd0);
    check("illegal_stock_5", {26'd0, stock_5}, 32'd2);
    check("illegal_stock_10", {26'd0, stock_10}, 32'd2);

    // Saturation at 63
    refill_valid = 1'b1;
    refill_coin  = 4'd1;
    for (int i = 0; i < 70; i++) step();
    refill_valid = 1'b0;
    check("sat_stock_1", {26'd0, stock_1}, 32'd63);

    // Reset while presenting a coin of a 30 payout
    coin_ready = 1'b0;
    start      = 1'b1;
    amount     = 8'd30;
    step();
    start = 1'b0;
    wait_valid();
    check("pre_rst_value", {28'd0, coin_value}, 32'd10);
    rst = 1'b1;
    step();
    rst        = 1'b0;
    coin_ready = 1'b1;
    check("mid_rst_valid", {31'd0, coin_valid}, 32'd0);
    check("mid_rst_remaining", {24'd0, remaining}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_stock_1", {26'd0, stock_1}, 32'd10);
    check("mid_rst_stock_5", {26'd0, stock_5}, 32'd10);
    check("mid_rst_stock_10", {26'd0, stock_10}, 32'd10);

    // amount=0: done exactly two cycles after start, no coins
    start  = 1'b1;
    amount = 8'd0;
    step();
    start = 1'b0;
    check("zero_c1_done", {31'd0, done}, 32'd0);
    check("zero_c1_busy", {31'd0, busy}, 32'd1);
    check("zero_c1_valid", {31'd0, coin_valid}, 32'd0);
    step();
    check("zero_c2_done", {31'd0, done}, 32'd1);
    check("zero_c2_valid", {31'd0, coin_valid}, 32'd0);
    step();
    check("zero_c3_done", {31'd0, done}, 32'd0);
    check("zero_c3_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_change_dispenser

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Return-side counterpart of the coin-acceptance logic: validated coins (1/5/10 NIS) go in there; this block pays change out.
- Takes a change amount and emits a sequence of legal coins, one at a time, to the coin hopper using a valid/ready handshake.
- Keeps a per-denomination stock count, refilled by the service port.
- Sits between the vending controller (sends start/amount, receives done/short_err) and the hopper driver.

Parameters:
- AMT_W, 8, width of the change amount and remaining counter (NIS).
- CNT_W, 6, width of each stock counter; counters saturate at 2^CNT_W-1.
- INIT_STOCK, 10, stock value loaded into every denomination on reset.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to dispense amount; honoured only in IDLE.
- amount  in  AMT_W  change to return; sampled on the accepted start.
- refill_valid  in  1  service refill strobe; adds one coin per cycle.
- refill_coin  in  4  denomination refilled; only 1, 5 and 10 are legal.
- coin_ready  in  1  hopper can take a coin this cycle.
- coin_valid  out  1  coin_value is being presented to the hopper.
- coin_value  out  4  denomination presented (1, 5 or 10); 0 when coin_valid=0.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: full amount paid.
- short_err  out  1  one-cycle pulse: stock insufficient; dispensing aborted.
- remaining  out  AMT_W  change not yet paid.
- stock_1, stock_5, stock_10  out  CNT_W each  current coin counts.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - coin_valid=0, coin_value=0, busy=0, done=0, short_err=0, remaining=0.
  - All stocks = INIT_STOCK.
  - Reset mid-dispense aborts immediately. The coin being presented is not counted.
- States: IDLE, SELECT, PRESENT, DONE, ERROR.
- IDLE:
  - start=1 latches remaining<=amount and goes to SELECT.
  - start in any other state is ignored.
- SELECT (one cycle, combinational pick, registered result):
  - remaining==0 -> DONE.
  - Otherwise pick greedy:
    - 10 if remaining>=10 and stock_10>0,
    - else 5 if remaining>=5 and stock_5>0,
    - else 1 if stock_1>0.
  - A coin is picked -> register coin_value and go to PRESENT.
  - No coin possible -> ERROR.
- PRESENT:
  - coin_valid=1; coin_value is held stable until the handshake.
  - Transfer occurs on a cycle where coin_valid && coin_ready.
  - On transfer: remaining -= coin_value, matching stock -= 1, coin_valid drops, state -> SELECT.
  - coin_ready may stay low indefinitely; hold with no timeout.
  - Minimum per coin is 2 cycles (SELECT + PRESENT).
- DONE: done=1 for exactly one cycle, then IDLE.
- ERROR:
  - short_err=1 for exactly one cycle, then IDLE.
  - remaining keeps the unpaid value until the next accepted start, so the controller can report it.
- Refill:
  - Accepted in any state.
  - Legal coin increments its stock, saturating at max. Illegal value (e.g. 0, 2, 15) is ignored.
  - Refill and dispense of the same denomination in one cycle: net change 0.
  - Refill during SELECT is visible to the selection on the following cycle only.
- Arithmetic:
  - remaining never underflows, because a coin is only picked when it is <= remaining.
  - Stock decrement is never issued at 0.
- amount=0: sequence is IDLE->SELECT->DONE; done pulses 2 cycles after start with no coins.

Decomposition:
- Shared package (vending_pkg):
  - Coin constants COIN_1=4'd1, COIN_5=4'd5, COIN_10=4'd10.
  - State enum for this FSM.
  - Coin-legality function, shared with the acceptance logic.
- One natural sub-module: coin_stock (three saturating up/down counters with refill validation, dec strobe and coin select). FSM and datapath stay in change_dispenser.

Test Plan:
- Reset, then start with amount=17, coin_ready=1 -> coins 10, 5, 1, 1 in order; done pulse; remaining=0; stock_10=9, stock_5=9, stock_1=8.
- stock_10=0 (INIT_STOCK=10, after ten 10-NIS dispenses), amount=20 -> coins 5,5,5,5; done pulse.
- stock_5=0 and stock_1=2, amount=8 -> coins 1,1; then short_err pulse; remaining=6; busy=0 the following cycle.
- coin_ready held low 5 cycles during PRESENT with coin 10 -> coin_valid=1 and coin_value=10 are stable throughout; single decrement after ready rises; second start during busy is ignored.
- refill_valid with refill_coin=5 in the same cycle a 5 transfers -> stock_5 unchanged. refill_coin=7 -> no stock change. Refill at max (63) -> stays 63.
- Assert rst mid-PRESENT for amount=30 -> next cycle coin_valid=0, remaining=0, stocks=10, state IDLE; amount=0 start -> done exactly 2 cycles later.
